// File: rtl/dll_replay_buffer_if.sv
// Replay-buffer link bundle: upstream TLP words, ACK/NAK DLLP strobe, downstream words.
// master = link-layer environment side, slave = replay buffer side.
interface dll_replay_buffer_if #(
  parameter int DATA_W = 16,
  parameter int SEQ_W  = 12
);
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_last;
  logic              tx_ready;
  logic [SEQ_W-1:0]  tx_seq;
  logic              acknak_valid;
  logic              acknak_nak;
  logic [SEQ_W-1:0]  acknak_seq;
  logic              ack_err;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;
  logic              out_replay;
  logic              retrain_req;

  modport master (
    output tx_valid, tx_data, tx_last, acknak_valid, acknak_nak, acknak_seq, out_ready,
    input  tx_ready, tx_seq, ack_err, out_valid, out_data, out_last, out_replay, retrain_req
  );

  modport slave (
    input  tx_valid, tx_data, tx_last, acknak_valid, acknak_nak, acknak_seq, out_ready,
    output tx_ready, tx_seq, ack_err, out_valid, out_data, out_last, out_replay, retrain_req
  );
endinterface

// File: rtl/dll_replay_buffer.sv
// DLL replay buffer: stores TLP words until ACKed, replays on NAK/timeout; write-to-out latency 1 cycle.
// tx_ready drops when full or replaying; out_* holds under out_ready=0. DLL_REPLAY_NUM_EN adds retrain on 4th replay.
module dll_replay_buffer #(
  parameter int DATA_W         = 16,
  parameter int DEPTH          = 64,
  parameter int MAX_TLPS       = 16,
  parameter int SEQ_W          = 12,
  parameter int REPLAY_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  dll_replay_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(MAX_TLPS);
  localparam int CW = $clog2(REPLAY_TIMEOUT + 1);

  localparam logic [1:0] ST_NORMAL = 2'd0;
  localparam logic [1:0] ST_PEND   = 2'd1;
  localparam logic [1:0] ST_REPLAY = 2'd2;

  localparam logic [AW:0]      DEPTH_P = (AW+1)'(DEPTH);
  localparam logic [SEQ_W-1:0] MAX_P   = SEQ_W'(MAX_TLPS);
  localparam logic [CW-1:0]    TMO_P   = CW'(REPLAY_TIMEOUT - 1);

  logic [DATA_W:0]    mem [DEPTH];
  logic [AW:0]        tlp_q [MAX_TLPS];
  logic [AW:0]        head, rd, tail, replay_end;
  logic [SEQ_W-1:0]   next_seq, acked_seq;
  logic [1:0]         state;
  logic [CW-1:0]      timer;
  logic               in_tlp, out_mid, ready_en, ack_err_q, retrain_q;

  logic [AW:0]        word_cnt, purge_head, head_nxt, tail_nxt;
  logic [SEQ_W-1:0]   tlp_cnt, ack_d, seq_after;
  logic [DATA_W:0]    rd_word;
  logic               tx_acc, out_acc, out_vld, ack_ok, purge, ack_purge;
  logic               jump, expire, trig, enter, replay_done;

  assign word_cnt  = tail - head;
  assign tlp_cnt   = next_seq - acked_seq - SEQ_W'(1);
  assign out_vld   = (rd != tail);
  assign rd_word   = mem[rd[AW-1:0]];
  assign tx_acc    = bus.tx_valid & bus.tx_ready;
  assign out_acc   = out_vld & bus.out_ready;
  assign tail_nxt  = tail + {{AW{1'b0}}, tx_acc};

  // Window check: offset 0 is a duplicate of the last ACK, tlp_cnt is the newest TLP.
  assign ack_d     = bus.acknak_seq - acked_seq;
  assign ack_ok    = (ack_d <= tlp_cnt);
  assign purge     = bus.acknak_valid & ack_ok & (ack_d != '0);
  assign ack_purge = purge & ~bus.acknak_nak;
  assign seq_after = bus.acknak_seq + SEQ_W'(1);
  // The TLP after S is either queued, the partial one being written, or not started yet.
  assign purge_head = ((seq_after == next_seq) && !in_tlp) ? tail : tlp_q[seq_after[TW-1:0]];
  assign head_nxt   = purge ? purge_head : head;

  assign jump   = purge & ~out_mid & ((purge_head - head) > (rd - head));
  assign expire = (state == ST_NORMAL) & (head != rd) & (timer == TMO_P);
  assign trig   = (state == ST_NORMAL) & ((bus.acknak_valid & bus.acknak_nak) | expire);
  assign enter  = ~out_mid & (trig | (state == ST_PEND));
  assign replay_done = (state == ST_REPLAY) &
                       ((rd == replay_end) | (out_acc & ((rd + (AW+1)'(1)) == replay_end)));

  assign bus.tx_ready    = ready_en & (state == ST_NORMAL) & (word_cnt < DEPTH_P) & (tlp_cnt < MAX_P);
  assign bus.tx_seq      = next_seq;
  assign bus.out_valid   = out_vld;
  assign bus.out_data    = out_vld ? rd_word[DATA_W-1:0] : '0;
  assign bus.out_last    = out_vld & rd_word[DATA_W];
  assign bus.out_replay  = (state == ST_REPLAY);
  assign bus.ack_err     = ack_err_q;
  assign bus.retrain_req = retrain_q;

  always_ff @(posedge clk) begin
    if (tx_acc) begin
      mem[tail[AW-1:0]] <= {bus.tx_last, bus.tx_data};
    end
    if (tx_acc && !in_tlp) begin
      tlp_q[next_seq[TW-1:0]] <= tail;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      rd         <= '0;
      tail       <= '0;
      replay_end <= '0;
      next_seq   <= '0;
      acked_seq  <= '1;
      state      <= ST_NORMAL;
      timer      <= '0;
      in_tlp     <= 1'b0;
      out_mid    <= 1'b0;
      ready_en   <= 1'b0;
      ack_err_q  <= 1'b0;
    end else begin
      ready_en  <= 1'b1;
      ack_err_q <= bus.acknak_valid & ~ack_ok;
      tail      <= tail_nxt;
      head      <= head_nxt;

      if (tx_acc) begin
        in_tlp <= ~bus.tx_last;
        if (bus.tx_last) begin
          next_seq <= next_seq + SEQ_W'(1);
        end
      end

      if (bus.acknak_valid && ack_ok) begin
        acked_seq <= bus.acknak_seq;
      end

      // Replay restart wins over a purge skip, which wins over normal streaming.
      if (enter) begin
        rd         <= head_nxt;
        replay_end <= tail_nxt;
        out_mid    <= 1'b0;
      end else if (jump) begin
        rd      <= purge_head;
        out_mid <= 1'b0;
      end else if (out_acc) begin
        rd      <= rd + (AW+1)'(1);
        out_mid <= ~bus.out_last;
      end

      case (state)
        ST_NORMAL: begin
          if (enter)     state <= ST_REPLAY;
          else if (trig) state <= ST_PEND;
        end
        ST_PEND: begin
          if (enter) state <= ST_REPLAY;
        end
        ST_REPLAY: begin
          if (replay_done) state <= ST_NORMAL;
        end
        default: state <= ST_NORMAL;
      endcase

      if (ack_purge || enter || (head == rd)) begin
        timer <= '0;
      end else if (state == ST_NORMAL) begin
        timer <= timer + CW'(1);
      end
    end
  end

`ifdef DLL_REPLAY_NUM_EN
  logic [1:0] replay_num;
  logic [1:0] replay_base;

  assign replay_base = ack_purge ? 2'd0 : replay_num;

  always_ff @(posedge clk) begin
    if (rst) begin
      replay_num <= 2'd0;
      retrain_q  <= 1'b0;
    end else begin
      retrain_q  <= enter & (replay_base == 2'd3);
      replay_num <= replay_base + {1'b0, enter};
    end
  end
`else
  assign retrain_q = 1'b0;
`endif

endmodule

// File: tb/tb_dll_replay_buffer.sv
// Directed bench for dll_replay_buffer: fill/drain, ACK/NAK purge, timeout replay, seq wrap, reset.
module tb_dll_replay_buffer;
  localparam int DATA_W   = 16;
  localparam int DEPTH    = 16;
  localparam int MAX_TLPS = 8;
  localparam int SEQ_W    = 12;
  localparam int TMO      = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dll_replay_buffer_if #(.DATA_W(DATA_W), .SEQ_W(SEQ_W)) bus();

  dll_replay_buffer #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_TLPS(MAX_TLPS), .SEQ_W(SEQ_W), .REPLAY_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic [17:0] mon_q[$];
  int          ack_err_cnt = 0;
  int          rdy_in_replay = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready)
        mon_q.push_back({bus.out_replay, bus.out_last, bus.out_data});
      if (bus.ack_err) ack_err_cnt++;
      if (bus.out_replay && bus.tx_ready) rdy_in_replay++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_word(input logic [15:0] d, input logic last);
    int t = 0;
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    bus.tx_last  = last;
    while (!bus.tx_ready && t < 200) begin
      step();
      t++;
    end
    if (t >= 200) check("tx_ready_wait", 32'(bus.tx_ready), 32'd1);
    step();
    bus.tx_valid = 1'b0;
    bus.tx_last  = 1'b0;
  endtask

  task automatic send_tlp(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) push_word(base + 16'(i), (i == n - 1));
  endtask

  task automatic acknak(input logic [11:0] s, input logic nak);
    bus.acknak_valid = 1'b1;
    bus.acknak_nak   = nak;
    bus.acknak_seq   = s;
    step();
    bus.acknak_valid = 1'b0;
    bus.acknak_nak   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    int t;
    int errs_before;
    logic [17:0] exp_w;

    bus.tx_valid = 0; bus.tx_data = 0; bus.tx_last = 0;
    bus.acknak_valid = 0; bus.acknak_nak = 0; bus.acknak_seq = 0;
    bus.out_ready = 0;

    // Reset values, then tx_ready one cycle after release
    step(3);
    check("rst_tx_ready", 32'(bus.tx_ready), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_tx_seq", 32'(bus.tx_seq), 0);
    check("rst_out_replay", 32'(bus.out_replay), 0);
    check("rst_retrain", 32'(bus.retrain_req), 0);
    rst = 1'b0;
    step();
    check("rel_tx_ready", 32'(bus.tx_ready), 1);

    // Three 4-word TLPs streamed straight through
    bus.out_ready = 1'b1;
    base = mon_q.size();
    push_word(16'h1000, 1'b0);
    check("t1_lat_valid", 32'(bus.out_valid), 1);
    check("t1_lat_data", 32'(bus.out_data), 32'h1000);
    push_word(16'h1001, 1'b0);
    push_word(16'h1002, 1'b0);
    push_word(16'h1003, 1'b1);
    check("t1_seq1", 32'(bus.tx_seq), 1);
    send_tlp(16'h1004, 4);
    check("t1_seq2", 32'(bus.tx_seq), 2);
    send_tlp(16'h1008, 4);
    check("t1_seq3", 32'(bus.tx_seq), 3);
    step(3);
    check("t1_count", 32'(mon_q.size() - base), 12);
    for (int i = 0; i < 12; i++) begin
      exp_w = {1'b0, (i % 4 == 3), 16'h1000 + 16'(i)};
      check($sformatf("t1_word%0d", i), 32'(mon_q[base + i]), 32'(exp_w));
    end

    // ACK 1 purges two TLPs; ACK 7 is outside the window
    acknak(12'd1, 1'b0);
    check("t2_ack_err", 32'(bus.ack_err), 0);
    check("t2_word_cnt", 32'(dut.word_cnt), 4);
    acknak(12'd7, 1'b0);
    check("t2_bad_ack_err", 32'(bus.ack_err), 1);
    check("t2_bad_word_cnt", 32'(dut.word_cnt), 4);
    step();
    check("t2_ack_err_pulse", 32'(bus.ack_err), 0);

    // NAK 0 purges TLP 0 and replays TLPs 1,2
    do_reset();
    bus.out_ready = 1'b1;
    send_tlp(16'h2000, 4);
    send_tlp(16'h2004, 4);
    send_tlp(16'h2008, 4);
    step(2);
    base = mon_q.size();
    acknak(12'd0, 1'b1);
    check("t3_replay", 32'(bus.out_replay), 1);
    check("t3_first", 32'(bus.out_data), 32'h2004);
    check("t3_tx_ready", 32'(bus.tx_ready), 0);
    check("t3_ack_err", 32'(bus.ack_err), 0);
    t = 0;
    while (bus.out_replay && t < 50) begin step(); t++; end
    check("t3_replay_len", 32'(t), 8);
    check("t3_count", 32'(mon_q.size() - base), 8);
    for (int i = 0; i < 8; i++) begin
      exp_w = {1'b1, (i % 4 == 3), 16'h2004 + 16'(i)};
      check($sformatf("t3_word%0d", i), 32'(mon_q[base + i]), 32'(exp_w));
    end
    check("t3_rdy_in_replay", 32'(rdy_in_replay), 0);
    check("t3_tx_ready_after", 32'(bus.tx_ready), 1);
    acknak(12'd2, 1'b0);
    check("t3_purge_all", 32'(dut.word_cnt), 0);

    // Replay timer: four consecutive expiries of one 2-word TLP
    send_tlp(16'h3000, 2);
    for (int r = 0; r < 4; r++) begin
      t = 0;
      while (!bus.out_replay && t < 300) begin step(); t++; end
      check($sformatf("t4_tmo%0d", r), 32'(t), TMO);
      check($sformatf("t4_data%0d", r), 32'(bus.out_data), 32'h3000);
`ifdef DLL_REPLAY_NUM_EN
      check($sformatf("t4_retrain%0d", r), 32'(bus.retrain_req), (r == 3) ? 1 : 0);
`else
      check($sformatf("t4_retrain%0d", r), 32'(bus.retrain_req), 0);
`endif
      t = 0;
      while (bus.out_replay && t < 50) begin step(); t++; end
      check($sformatf("t4_len%0d", r), 32'(t), 2);
    end
    acknak(12'd3, 1'b0);
    check("t4_purge", 32'(dut.word_cnt), 0);

    // Fill to DEPTH with downstream stalled, ACK releases space
    do_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_tlp(16'h4000 + 16'(4 * k), 4);
    check("t5_full_ready", 32'(bus.tx_ready), 0);
    acknak(12'd0, 1'b0);
    check("t5_ready_after_ack", 32'(bus.tx_ready), 1);
    check("t5_out_valid", 32'(bus.out_valid), 1);
    check("t5_rd_skip", 32'(bus.out_data), 32'h4004);

    // Sequence number wrap 4095 -> 0 with one-word TLPs
    do_reset();
    bus.out_ready = 1'b1;
    errs_before = ack_err_cnt;
    for (int i = 0; i < 4096; i++) begin
      push_word(16'(i), 1'b1);
      if (i == 4094) check("t6_seq4095", 32'(bus.tx_seq), 4095);
      acknak(12'(i), 1'b0);
    end
    check("t6_seq_wrap", 32'(bus.tx_seq), 0);
    check("t6_no_ack_err", 32'(ack_err_cnt - errs_before), 0);

    // Reset in the middle of a stalled replay
    do_reset();
    bus.out_ready = 1'b1;
    send_tlp(16'h5000, 2);
    step(2);
    bus.out_ready = 1'b0;
    acknak(12'hFFF, 1'b1);
    check("t7_replay", 32'(bus.out_replay), 1);
    check("t7_valid", 32'(bus.out_valid), 1);
    check("t7_ack_err", 32'(bus.ack_err), 0);
    rst = 1'b1;
    step();
    check("t7_rst_valid", 32'(bus.out_valid), 0);
    check("t7_rst_seq", 32'(bus.tx_seq), 0);
    check("t7_rst_replay", 32'(bus.out_replay), 0);
    check("t7_rst_ready", 32'(bus.tx_ready), 0);
    rst = 1'b0;
    step();
    check("t7_rel_ready", 32'(bus.tx_ready), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
